// File: rtl/fetch_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_aligner_if
//  Description : Instruction-memory, redirect and instruction-output bundle
//                for the fetch aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_aligner_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic        instr_is_c;
    logic [31:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        output instr_is_c,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        input  instr_is_c,
        input  instr_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_aligner
//  Description : Halfword-buffered RV32IC fetch front end; emits one 16- or
//                32-bit instruction per handshake from word-aligned fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    fetch_aligner_if.master bus
);

    localparam logic [31:0] c_reset_head  = {RESET_PC[31:1], 1'b0};
    localparam logic [31:0] c_reset_fetch = {RESET_PC[31:2], 2'b00};

    // Halfword 0 of r_buf is the head; slots at or above r_count are zero.
    logic [63:0] r_buf;
    logic [2:0]  r_count;
    logic [31:0] r_head_pc;
    logic [31:0] r_fetch_addr;
    logic        r_inflight;
    logic        r_skip;

    logic [15:0] w_head;
    logic        w_head_is_c;
    logic        w_avail;
    logic        w_valid;
    logic        w_xfer;
    logic [2:0]  w_consumed;
    logic [2:0]  w_kept;
    logic [3:0]  w_occ;
    logic        w_req;
    logic [31:0] w_size;
    logic [63:0] w_shifted;
    logic [63:0] w_resp;
    logic [2:0]  w_resp_n;
    logic [63:0] w_buf_next;
    logic [2:0]  w_count_next;

    assign w_head      = r_buf[15:0];
    assign w_head_is_c = (w_head[1:0] != 2'b11);
    assign w_avail     = w_head_is_c ? (r_count >= 3'd1) : (r_count >= 3'd2);
    assign w_valid     = w_avail && !bus.redirect_valid;
    assign w_xfer      = w_valid && bus.instr_ready;
    assign w_consumed  = !w_xfer ? 3'd0 : (w_head_is_c ? 3'd1 : 3'd2);
    assign w_kept      = r_count - w_consumed;
    assign w_size      = w_head_is_c ? 32'd2 : 32'd4;

    // Occupancy counts the in-flight word so the buffer can never overflow.
    assign w_occ = {1'b0, r_count} - {1'b0, w_consumed} + {2'b00, r_inflight, 1'b0};
    assign w_req = !rst && !bus.redirect_valid && (w_occ <= 4'd2);

    assign w_shifted  = r_buf >> {w_consumed, 4'b0000};
    assign w_resp     = r_skip ? {48'h0, bus.imem_rdata[31:16]} : {32'h0, bus.imem_rdata};
    assign w_resp_n   = r_skip ? 3'd1 : 3'd2;
    assign w_buf_next = r_inflight ? (w_shifted | (w_resp << {w_kept, 4'b0000})) : w_shifted;
    assign w_count_next = r_inflight ? (w_kept + w_resp_n) : w_kept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf        <= 64'h0;
            r_count      <= 3'd0;
            r_head_pc    <= c_reset_head;
            r_fetch_addr <= c_reset_fetch;
            r_inflight   <= 1'b0;
            r_skip       <= RESET_PC[1];
        end else if (bus.redirect_valid) begin
            r_buf        <= 64'h0;
            r_count      <= 3'd0;
            r_head_pc    <= {bus.redirect_pc[31:1], 1'b0};
            r_fetch_addr <= {bus.redirect_pc[31:2], 2'b00};
            r_inflight   <= 1'b0;
            r_skip       <= bus.redirect_pc[1];
        end else begin
            r_buf      <= w_buf_next;
            r_count    <= w_count_next;
            r_inflight <= w_req;
            if (w_xfer) begin
                r_head_pc <= r_head_pc + w_size;
            end
            if (w_req) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (r_inflight) begin
                r_skip <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_addr;
    assign bus.instr_valid = w_valid;
    assign bus.instr_out   = w_head_is_c ? {16'h0, w_head} : r_buf[31:0];
    assign bus.instr_is_c  = w_head_is_c && (r_count != 3'd0);
    assign bus.instr_pc    = r_head_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_aligner
//  Description : Self-checking bench: directed scenarios plus random traffic
//                scored against a PC-driven instruction-stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;
    fetch_aligner_if bus ();

    fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    // Synchronous-read memory; garbage on idle cycles exposes spurious captures.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? mem[bus.imem_addr[9:2]] : $urandom();
    end

    int          checks;
    int          errors;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic        hold_flag;
    logic [31:0] held_out;
    logic [31:0] held_pc;
    logic        held_c;

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [15:0] lo;
        lo = hw(pc);
        if (lo[1:0] != 2'b11) return {16'h0, lo};
        return {hw(pc + 32'd2), lo};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; moves to the falling edge and scores the cycle.
    task automatic sample();
        logic [31:0] e;
        #4;
        if (!rst) begin
            if (bus.redirect_valid) begin
                chk("redir_blocks_valid", {31'b0, bus.instr_valid}, 32'd0);
                chk("redir_blocks_req", {31'b0, bus.imem_req}, 32'd0);
            end
            if (bus.imem_req) chk("imem_addr", bus.imem_addr, exp_fetch);
            if (hold_flag && !bus.redirect_valid) begin
                chk("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
                chk("hold_out", bus.instr_out, held_out);
                chk("hold_pc", bus.instr_pc, held_pc);
                chk("hold_is_c", {31'b0, bus.instr_is_c}, {31'b0, held_c});
            end
            if (bus.instr_valid) begin
                e = exp_instr(exp_pc);
                chk("instr_pc", bus.instr_pc, exp_pc);
                chk("instr_out", bus.instr_out, e);
                chk("instr_is_c", {31'b0, bus.instr_is_c}, {31'b0, e[1:0] != 2'b11});
            end
            hold_flag = bus.instr_valid && !bus.instr_ready;
            held_out  = bus.instr_out;
            held_pc   = bus.instr_pc;
            held_c    = bus.instr_is_c;
        end else begin
            hold_flag = 1'b0;
        end
    endtask

    task automatic adv();
        logic        p_rst, p_redir, p_req, p_xfer;
        logic [31:0] p_rpc, p_size;
        logic [15:0] h;
        p_rst   = rst;
        p_redir = bus.redirect_valid;
        p_rpc   = bus.redirect_pc;
        p_req   = bus.imem_req;
        p_xfer  = bus.instr_valid && bus.instr_ready;
        h       = hw(exp_pc);
        p_size  = (h[1:0] != 2'b11) ? 32'd2 : 32'd4;
        @(posedge clk);
        if (p_rst) begin
            exp_pc    = RESET_PC;
            exp_fetch = RESET_PC;
        end else if (p_redir) begin
            exp_pc    = p_rpc & ~32'd1;
            exp_fetch = p_rpc & ~32'd3;
        end else begin
            if (p_xfer) exp_pc = exp_pc + p_size;
            if (p_req) exp_fetch = exp_fetch + 32'd4;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic rst_on();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        cyc();
    endtask

    task automatic rst_finish();
        sample();
        chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_instr_out", bus.instr_out, 32'd0);
        chk("rst_instr_is_c", {31'b0, bus.instr_is_c}, 32'd0);
        chk("rst_instr_pc", bus.instr_pc, RESET_PC);
        adv();
        rst = 1'b0;
    endtask

    // Leaves the bench at the falling edge of the first valid cycle.
    task automatic wait_valid(input int max, input string tag);
        int n;
        n = 0;
        sample();
        while (bus.instr_valid !== 1'b1 && n < max) begin
            adv();
            sample();
            n++;
        end
        chk(tag, {31'b0, bus.instr_valid}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        hold_flag = 1'b0;
        exp_pc = RESET_PC;
        exp_fetch = RESET_PC;
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        @(posedge clk);
        #1;

        // Single 32-bit instruction: request in cycle 0, valid in cycle 2
        rst_on();
        mem[0] = 32'h0000_0013;
        rst_finish();
        sample();
        chk("c0_req", {31'b0, bus.imem_req}, 32'd1);
        chk("c0_addr", bus.imem_addr, 32'd0);
        chk("c0_valid", {31'b0, bus.instr_valid}, 32'd0);
        adv();
        sample();
        chk("c1_valid", {31'b0, bus.instr_valid}, 32'd0);
        adv();
        sample();
        chk("c2_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("c2_out", bus.instr_out, 32'h0000_0013);
        chk("c2_is_c", {31'b0, bus.instr_is_c}, 32'd0);
        chk("c2_pc", bus.instr_pc, 32'd0);
        adv();
        repeat (6) cyc();

        // Two compressed halves of one word
        rst_on();
        mem[0] = 32'h4505_1141;
        rst_finish();
        cyc();
        cyc();
        sample();
        chk("cc_pc0", bus.instr_pc, 32'd0);
        chk("cc_out0", bus.instr_out, 32'h0000_1141);
        chk("cc_c0", {31'b0, bus.instr_is_c}, 32'd1);
        adv();
        sample();
        chk("cc_pc2", bus.instr_pc, 32'd2);
        chk("cc_out2", bus.instr_out, 32'h0000_4505);
        chk("cc_c2", {31'b0, bus.instr_is_c}, 32'd1);
        adv();
        sample();
        chk("cc_valid4", {31'b0, bus.instr_valid}, 32'd1);
        chk("cc_pc4", bus.instr_pc, 32'd4);
        adv();
        repeat (4) cyc();

        // 32-bit instruction straddling a word boundary
        rst_on();
        mem[0] = 32'h0513_1141;
        mem[1] = 32'hABCD_0010;
        rst_finish();
        wait_valid(4, "st_first_valid");
        chk("st_pc0", bus.instr_pc, 32'd0);
        chk("st_out0", bus.instr_out, 32'h0000_1141);
        adv();
        wait_valid(3, "st_second_valid");
        chk("st_pc2", bus.instr_pc, 32'd2);
        chk("st_out2", bus.instr_out, 32'h0010_0513);
        chk("st_c2", {31'b0, bus.instr_is_c}, 32'd0);
        adv();
        repeat (4) cyc();

        // All-32-bit stream with a 5-cycle downstream stall
        rst_on();
        for (int i = 0; i < 256; i++) mem[i] = $urandom() | 32'h3;
        rst_finish();
        wait_valid(4, "stall_first_valid");
        adv();
        repeat (4) cyc();
        bus.instr_ready = 1'b0;
        cyc();
        cyc();
        sample();
        chk("stall_req_drop", {31'b0, bus.imem_req}, 32'd0);
        adv();
        cyc();
        cyc();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("stall_throughput", {31'b0, bus.instr_valid}, 32'd1);
            adv();
        end

        // Redirect to 0x106 while a fetch is in flight
        mem[8'h41] = 32'h4505_0003;
        sample();
        chk("rd_inflight_req", {31'b0, bus.imem_req}, 32'd1);
        adv();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0106;
        cyc();
        bus.redirect_valid = 1'b0;
        sample();
        chk("rd_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rd_addr", bus.imem_addr, 32'h0000_0104);
        chk("rd_r1_valid", {31'b0, bus.instr_valid}, 32'd0);
        adv();
        sample();
        chk("rd_r2_valid", {31'b0, bus.instr_valid}, 32'd0);
        adv();
        sample();
        chk("rd_r3_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("rd_pc", bus.instr_pc, 32'h0000_0106);
        chk("rd_out", bus.instr_out, 32'h0000_4505);
        chk("rd_is_c", {31'b0, bus.instr_is_c}, 32'd1);
        adv();
        repeat (3) cyc();

        // Redirect onto a 32-bit instruction whose low half sits in the upper word half
        mem[8'h82] = {16'h0513, 16'h1234};
        mem[8'h83] = {16'h5678, 16'h0010};
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_020A;
        cyc();
        bus.redirect_valid = 1'b0;
        cyc();
        cyc();
        sample();
        chk("rd32_partial_valid", {31'b0, bus.instr_valid}, 32'd0);
        adv();
        sample();
        chk("rd32_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("rd32_pc", bus.instr_pc, 32'h0000_020A);
        chk("rd32_out", bus.instr_out, 32'h0010_0513);
        adv();
        repeat (3) cyc();

        // One-cycle reset in the middle of the stream
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sample();
        chk("mr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("mr_out", bus.instr_out, 32'd0);
        chk("mr_is_c", {31'b0, bus.instr_is_c}, 32'd0);
        chk("mr_pc", bus.instr_pc, RESET_PC);
        chk("mr_req", {31'b0, bus.imem_req}, 32'd1);
        chk("mr_addr", bus.imem_addr, RESET_PC);
        adv();
        wait_valid(3, "mr_restart_valid");
        chk("mr_restart_pc", bus.instr_pc, RESET_PC);
        adv();

        // Random mixed stream with stalls, redirects (incl. near 2^32) and resets
        rst_on();
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        rst_finish();
        for (int k = 0; k < 500; k++) begin
            bus.instr_ready = ($urandom_range(3) != 0);
            bus.redirect_valid = ($urandom_range(19) == 0);
            if ($urandom_range(7) == 0)
                bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else
                bus.redirect_pc = $urandom() & 32'h0000_03FF;
            rst = ($urandom_range(99) == 0);
            cyc();
        end
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (6) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
